// File: rtl/traffic_signal_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_signal_ctrl
//
// Multi-phase traffic signal controller. Cycles through NUM_PHASES
// conflicting phases, each running GREEN -> YELLOW -> ALLRED, with
// tick-enabled interval timing, a green hold input and an optional
// pedestrian walk interval inserted after an all-red clearance.
//
// Optional feature macro: TRAFFIC_PED_EN
//   defined   : ped_req is latched into a pending flag; the next all-red exit
//               enters WALK and ped_ack pulses for one cycle.
//   undefined : ped_req is ignored, walk and ped_ack are tied low.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   tick_en  in   advance the interval counter on this edge
//   hold     in   keep the current phase green past its minimum
//   ped_req  in   pedestrian request (level or pulse)
//   green    out  one-hot green lamps, NUM_PHASES bits
//   yellow   out  one-hot yellow lamps, NUM_PHASES bits
//   red      out  red lamps, ~(green | yellow)
//   walk     out  pedestrian walk lamp
//   ped_ack  out  one-cycle pulse at walk start
//   phase    out  active / most recent phase index
//   count    out  interval counter
// -----------------------------------------------------------------------------
module traffic_signal_ctrl #(
    parameter int unsigned NUM_PHASES   = 2,
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tick_en,
    input  logic                          hold,
    input  logic                          ped_req,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic                          walk,
    output logic                          ped_ack,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [CNT_W-1:0]              count
);

    localparam int unsigned PH_W = $clog2(NUM_PHASES);

    localparam logic [CNT_W-1:0] GREEN_TERM  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_TERM = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_TERM = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_TERM   = CNT_W'(WALK_TICKS - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE  = PH_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_WALK
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PH_W-1:0]     next_phase;
    logic [CNT_W-1:0]    next_count;
    logic [CNT_W-1:0]    term;
    logic [PH_W-1:0]     phase_inc;
    logic                walk_ok;

    // -------------------------------------------------------------------------
    // State, phase and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_GREEN;
            phase <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            phase <= next_phase;
            count <= next_count;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, counter and lamp decode
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        next_phase = phase;
        next_count = count;
        term       = GREEN_TERM;
        phase_inc  = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
        green      = '0;
        yellow     = '0;

        case (state)
            ST_GREEN:  term = GREEN_TERM;
            ST_YELLOW: term = YELLOW_TERM;
            ST_ALLRED: term = ALLRED_TERM;
            ST_WALK:   term = WALK_TERM;
            default:   term = GREEN_TERM;
        endcase

        if (tick_en) begin
            if (count != term) begin
                next_count = count + 1'b1;
            end else begin
                case (state)
                    ST_GREEN: begin
                        // At terminal with hold asserted the counter just
                        // saturates; release exits on the next tick.
                        if (!hold) begin
                            next_state = ST_YELLOW;
                            next_count = '0;
                        end
                    end
                    ST_YELLOW: begin
                        next_state = ST_ALLRED;
                        next_count = '0;
                    end
                    ST_ALLRED: begin
                        next_count = '0;
                        if (walk_ok) begin
                            next_state = ST_WALK;
                        end else begin
                            next_state = ST_GREEN;
                            next_phase = phase_inc;
                        end
                    end
                    ST_WALK: begin
                        next_state = ST_GREEN;
                        next_phase = phase_inc;
                        next_count = '0;
                    end
                    default: begin
                        next_state = ST_GREEN;
                        next_count = '0;
                    end
                endcase
            end
        end

        // Moore lamp decode from registered state and phase
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            green[i]  = (state == ST_GREEN)  && (phase == PH_W'(i));
            yellow[i] = (state == ST_YELLOW) && (phase == PH_W'(i));
        end
    end

    assign red = ~(green | yellow);

    // -------------------------------------------------------------------------
    // Pedestrian interval
    // -------------------------------------------------------------------------
`ifdef TRAFFIC_PED_EN
    logic ped_pending;
    logic enter_walk;

    assign enter_walk = (state == ST_ALLRED) && (next_state == ST_WALK);
    assign walk_ok    = ped_pending;
    assign walk       = (state == ST_WALK);

    // A request arriving on the ALLRED->WALK edge is served by this walk,
    // so the clear takes priority over the set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_ack <= enter_walk;
            if (enter_walk) begin
                ped_pending <= 1'b0;
            end else if (ped_req && (state != ST_WALK)) begin
                ped_pending <= 1'b1;
            end
        end
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign walk_ok        = 1'b0;
    assign walk           = 1'b0;
    assign ped_ack        = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_signal_ctrl
//
// Directed bench for traffic_signal_ctrl: a vector table for the free-running
// two-phase sequence, plus hand-written sequences for hold, tick gating,
// pedestrian handling (TRAFFIC_PED_EN) and mid-interval async reset on a
// three-phase instance.
// -----------------------------------------------------------------------------
module tb_traffic_signal_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       hold;
    logic       ped_req;
    logic [1:0] green;
    logic [1:0] yellow;
    logic [1:0] red;
    logic       walk;
    logic       ped_ack;
    logic       phase;
    logic [3:0] count;

    logic       reset3;
    logic       tick3;
    logic       hold3;
    logic       ped3;
    logic [2:0] green3;
    logic [2:0] yellow3;
    logic [2:0] red3;
    logic       walk3;
    logic       ped_ack3;
    logic [1:0] phase3;
    logic [3:0] count3;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    traffic_signal_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .tick_en (tick_en),
        .hold    (hold),
        .ped_req (ped_req),
        .green   (green),
        .yellow  (yellow),
        .red     (red),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase),
        .count   (count)
    );

    traffic_signal_ctrl #(.NUM_PHASES(3)) dut3 (
        .clock   (clock),
        .reset   (reset3),
        .tick_en (tick3),
        .hold    (hold3),
        .ped_req (ped3),
        .green   (green3),
        .yellow  (yellow3),
        .red     (red3),
        .walk    (walk3),
        .ped_ack (ped_ack3),
        .phase   (phase3),
        .count   (count3)
    );

    typedef struct {
        logic       tick;
        logic       hold;
        logic       ped;
        logic [1:0] g;
        logic [1:0] y;
        logic [1:0] r;
        logic       w;
        logic       a;
        logic       ph;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] snap();
        return {green, yellow, red, walk, ped_ack, phase, count};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        tick_en = 1'b1;
        hold    = 1'b0;
        ped_req = 1'b0;
        #1;
        check("reset state", 32'(snap()), 32'(13'b01_00_10_0_0_0_0000));
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_table(input logic ped_lvl, input string tag);
        for (int k = 0; k < 23; k++) begin
            tick_en = vecs[k].tick;
            hold    = vecs[k].hold;
            ped_req = vecs[k].ped | ped_lvl;
            #1;
            check($sformatf("%s c%0d", tag, k), 32'(snap()),
                  32'({vecs[k].g, vecs[k].y, vecs[k].r, vecs[k].w, vecs[k].a,
                       vecs[k].ph, vecs[k].cnt}));
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first_y;
        int first_r;

        // Free-running two-phase sequence, hand-segmented per interval
        for (int i = 0; i < 23; i++) begin
            vecs[i].tick = 1'b1;
            vecs[i].hold = 1'b0;
            vecs[i].ped  = 1'b0;
            vecs[i].w    = 1'b0;
            vecs[i].a    = 1'b0;
            vecs[i].g    = 2'b00;
            vecs[i].y    = 2'b00;
            if (i <= 7) begin
                vecs[i].g = 2'b01; vecs[i].r = 2'b10; vecs[i].ph = 1'b0; vecs[i].cnt = 4'(i);
            end else if (i <= 9) begin
                vecs[i].y = 2'b01; vecs[i].r = 2'b10; vecs[i].ph = 1'b0; vecs[i].cnt = 4'(i - 8);
            end else if (i == 10) begin
                vecs[i].r = 2'b11; vecs[i].ph = 1'b0; vecs[i].cnt = 4'd0;
            end else if (i <= 18) begin
                vecs[i].g = 2'b10; vecs[i].r = 2'b01; vecs[i].ph = 1'b1; vecs[i].cnt = 4'(i - 11);
            end else if (i <= 20) begin
                vecs[i].y = 2'b10; vecs[i].r = 2'b01; vecs[i].ph = 1'b1; vecs[i].cnt = 4'(i - 19);
            end else if (i == 21) begin
                vecs[i].r = 2'b11; vecs[i].ph = 1'b1; vecs[i].cnt = 4'd0;
            end else begin
                vecs[i].g = 2'b01; vecs[i].r = 2'b10; vecs[i].ph = 1'b0; vecs[i].cnt = 4'd0;
            end
        end

        reset   = 1'b1;
        tick_en = 1'b1;
        hold    = 1'b0;
        ped_req = 1'b0;
        reset3  = 1'b1;
        tick3   = 1'b1;
        hold3   = 1'b0;
        ped3    = 1'b0;

        // Three-phase instance: async reset in phase 2 yellow
        @(negedge clock);
        reset3 = 1'b0;
        for (int k = 0; k < 30; k++) @(negedge clock);
        #1;
        check("p3 yellow phase2 c30", 32'({yellow3, phase3}), 32'({3'b100, 2'd2}));
        #2;
        reset3 = 1'b1;
        #1;
        check("p3 async reset", 32'({green3, yellow3, red3, phase3, count3}),
              32'({3'b001, 3'b000, 3'b110, 2'd0, 4'd0}));
        @(negedge clock);
        reset3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k == 8)  check("p3 restart yellow c8", 32'({yellow3, count3}), 32'({3'b001, 4'd0}));
            if (k == 10) check("p3 restart allred c10", 32'(red3), 32'(3'b111));
            if (k == 11) check("p3 restart green1 c11", 32'({green3, phase3}), 32'({3'b010, 2'd1}));
            @(negedge clock);
        end

        // Basic sequence from the vector table
        do_reset();
        run_table(1'b0, "basic");

        // Hold keeps phase 0 green with saturated count
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick_en = 1'b1;
            hold    = (k >= 5 && k <= 13);
            #1;
            if (k == 10) check("hold c10", 32'({green, count}), 32'({2'b01, 4'd7}));
            if (k == 14) check("hold c14", 32'({green, count}), 32'({2'b01, 4'd7}));
            if (k == 15) check("hold exit c15", 32'({green, yellow, count}), 32'({2'b00, 2'b01, 4'd0}));
            @(negedge clock);
        end
        hold = 1'b0;

        // Tick gating: tick only on odd cycles doubles every interval
        do_reset();
        first_y = -1;
        first_r = -1;
        for (int k = 0; k < 40; k++) begin
            tick_en = (k % 2 == 1);
            #1;
            if (k == 3) check("toggle count c3", 32'(count), 32'd1);
            if (k == 4) check("toggle count c4", 32'(count), 32'd2);
            if (first_y < 0 && yellow != 2'b00) first_y = k;
            if (first_r < 0 && red == 2'b11) first_r = k;
            @(negedge clock);
        end
        check("toggle first yellow", 32'(first_y), 32'd16);
        check("toggle first allred", 32'(first_r), 32'd20);

`ifdef TRAFFIC_PED_EN
        // Pedestrian pulse at cycle 3, ignored request during walk
        do_reset();
        for (int k = 0; k < 27; k++) begin
            tick_en = 1'b1;
            ped_req = (k == 3 || k == 12);
            #1;
            case (k)
                10: check("ped allred c10", 32'({red, walk, ped_ack}), 32'({2'b11, 1'b0, 1'b0}));
                11: check("ped walk start c11", 32'({red, walk, ped_ack, count}), 32'({2'b11, 1'b1, 1'b1, 4'd0}));
                12: check("ped ack pulse c12", 32'({walk, ped_ack}), 32'({1'b1, 1'b0}));
                14: check("ped walk end c14", 32'({red, walk, count}), 32'({2'b11, 1'b1, 4'd3}));
                15: check("ped green1 c15", 32'({green, walk, phase}), 32'({2'b10, 1'b0, 1'b1}));
                22: check("ped green1 c22", 32'({green, count}), 32'({2'b10, 4'd7}));
                25: check("ped allred1 c25", 32'({red, walk}), 32'({2'b11, 1'b0}));
                26: check("ped no walk c26", 32'({green, walk, ped_ack, phase}), 32'({2'b01, 1'b0, 1'b0, 1'b0}));
                default: ;
            endcase
            @(negedge clock);
        end
        ped_req = 1'b0;
`else
        // Pedestrian feature compiled out: held request changes nothing
        do_reset();
        run_table(1'b1, "pedheld");
        ped_req = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
